wb_sequencer: RTL and testbench
===============================

# wb_sequencer

Write-back sequencer for the multicycle datapath's register-file write port. Accepts one write-back request per instruction, waits until the selected source is valid, and then issues a single-cycle register write. The data sources are ALU, MDR, Hi, Lo, the constants 227/0/1, the shift register, and the lui path. It drives the 4-bit select of the write-back data mux plus the register-file write enable and destination, and sits between the main control FSM and the register bank.

## Interface
- MEM_WAIT, 2: cycles between request and valid MDR data for loads (1..15).
- TIMEOUT, 64: maximum cycles spent in any wait state before abort (2..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle write-back request.
- wb_kind  in  4  source code, sampled with start.
  - 0 ALU, 1 MDR, 2 Hi, 3 Lo, 4 const 227, 5 const 0, 6 const 1, 7 shift reg, 8 lui.
  - 9..15 illegal.
- dest  in  5  destination register, sampled with start.
- muldiv_busy  in  1  mult/div unit still computing Hi/Lo.
- shift_done  in  1  shift register result valid (level).
- flush  in  1  cancel any pending write-back (exception).
- mem_to_reg  out  4  write-back mux select.
- reg_write  out  1  register-file write enable.
- write_reg  out  5  register-file destination.
- busy  out  1  request in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse at completion, including suppressed writes.
- err  out  1  one-cycle pulse on illegal kind or timeout.

## Operation
- States:
  - IDLE
  - WAIT_MEM
  - WAIT_MULDIV
  - WAIT_SHIFT
  - WRITE
- IDLE + start (no flush):
  - latch wb_kind into mem_to_reg and dest into write_reg.
  - Next state by kind:
    - kinds 0, 4, 5, 6, 8 → WRITE.
    - kind 1 → WAIT_MEM, counter loaded with MEM_WAIT−1.
    - kinds 2, 3 → WAIT_MULDIV.
    - kind 7 → WAIT_SHIFT.
    - kinds 9..15 → stay IDLE, pulse err; no done, no write.
- WAIT_MEM: decrement the counter each cycle; when it reaches 0 → WRITE.
- WAIT_MULDIV: when muldiv_busy=0 → WRITE.
- WAIT_SHIFT: when shift_done=1 → WRITE.
- Watchdog: counts cycles in any wait state. If it reaches TIMEOUT → IDLE with an err pulse, no write, no done.
- WRITE: lasts exactly one cycle and then → IDLE.
  - reg_write=1 if write_reg≠0; write_reg=0 suppresses the write.
  - done=1 in both cases.
- mem_to_reg and write_reg hold their latched values from start until the next accepted start. They do not return to 0 in IDLE.
- start while busy=1: ignored, no err.
- flush, any state: → IDLE next edge; reg_write/done are not asserted.
  - flush wins over start in the same cycle.
  - flush in WRITE: the write in that cycle is masked combinationally.
- reset:
  - state IDLE, counters 0.
  - mem_to_reg=0, write_reg=0, reg_write=0, busy=0, done=0, err=0.
  - Reset asserted mid-wait drops the request with no write.

## Timing
- Cycle 0 is the start edge. reg_write, done, err are Moore outputs decoded from the registered state; the only combinational term is the flush mask.
- ALU/const/lui: reg_write high in cycle 1. The next start is accepted in cycle 2.
- MDR: reg_write high in cycle MEM_WAIT+1 (cycle 3 at default).
- Hi/Lo: reg_write high one cycle after the first cycle with muldiv_busy=0 is sampled in WAIT_MULDIV.
  - Minimum is cycle 2, when muldiv_busy is already 0 at cycle 1.
- Shift: same rule as Hi/Lo, keyed on shift_done=1.
- err for an illegal kind: cycle 1.
- err for a timeout: the cycle after TIMEOUT wait cycles.
- busy=1 from cycle 1 through the WRITE cycle inclusive.

## Structure
- Shared package wb_pkg:
  - WB_ALU..WB_LUI kind codes, shared with the write-back mux and the main control unit.
  - State encoding localparams.
- Sub-module wb_wait_counter holds the loadable down-counter and the watchdog counter, with load/enable/zero/timeout outputs.
- The FSM and output decode stay in wb_sequencer.

## Test plan
- start, kind=0, dest=8 → cycle 1: reg_write=1, write_reg=8, mem_to_reg=0, done=1. Cycle 2: busy=0.
- start, kind=1, dest=5, MEM_WAIT=2 → reg_write only in cycle 3, mem_to_reg=1 held from cycle 1.
- start, kind=2, muldiv_busy high for 10 cycles then low → exactly one reg_write, mem_to_reg=2, with no write while busy.
- start, kind=6, dest=0 → cycle 1: done=1, reg_write=0. Then start, kind=12 → err pulse, state IDLE, no done.
- Shift timeout and flush:
  - start, kind=7 with shift_done stuck 0, TIMEOUT=64 → err after 64 wait cycles, no write.
  - Repeat with flush in cycle 5 → IDLE in cycle 6, no err, no write.
- Reset and start-while-busy:
  - Reset asserted asynchronously mid-WAIT_MEM → all outputs 0 immediately.
  - start during busy → ignored, original request completes unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: write-back source codes and sequencer state encoding shared with the
// write-back mux and the main control unit.
package wb_pkg;

    localparam logic [3:0] WB_ALU   = 4'd0;
    localparam logic [3:0] WB_MDR   = 4'd1;
    localparam logic [3:0] WB_HI    = 4'd2;
    localparam logic [3:0] WB_LO    = 4'd3;
    localparam logic [3:0] WB_C227  = 4'd4;
    localparam logic [3:0] WB_C0    = 4'd5;
    localparam logic [3:0] WB_C1    = 4'd6;
    localparam logic [3:0] WB_SHIFT = 4'd7;
    localparam logic [3:0] WB_LUI   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_MEM    = 3'd1,
        S_WAIT_MULDIV = 3'd2,
        S_WAIT_SHIFT  = 3'd3,
        S_WRITE       = 3'd4
    } state_e;

    // First state after an accepted start; S_IDLE marks an illegal kind.
    function automatic state_e route(input logic [3:0] kind);
        return kind == WB_MDR ? S_WAIT_MEM :
               (kind == WB_HI || kind == WB_LO) ? S_WAIT_MULDIV :
               kind == WB_SHIFT ? S_WAIT_SHIFT :
               kind <= WB_LUI ? S_WRITE : S_IDLE;
    endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// wb_wait_counter: load-delay down-counter plus a saturating watchdog counting
// cycles spent in wait states.
module wb_wait_counter #(
    parameter int MEM_WAIT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero,
    output logic timeout
);

    logic [3:0] cnt;
    logic [7:0] wd;

    assign zero    = cnt == 4'd0;
    assign timeout = wd == 8'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt <= '0;
            wd  <= '0;
        end else if (load) begin
            cnt <= 4'(MEM_WAIT - 1);
            wd  <= '0;
        end else if (en) begin
            cnt <= zero ? cnt : cnt - 4'd1;
            wd  <= timeout ? wd : wd + 8'd1;
        end

endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: accepts one write-back request, waits for its source to become
// valid and issues a single-cycle register-file write.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] wb_kind,
    input  logic [4:0] dest,
    input  logic       muldiv_busy,
    input  logic       shift_done,
    input  logic       flush,
    output logic [3:0] mem_to_reg,
    output logic       reg_write,
    output logic [4:0] write_reg,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e state, state_n;
    logic   accept, waiting, ready, err_n, zero, timeout;

    wb_wait_counter #(.MEM_WAIT(MEM_WAIT), .TIMEOUT(TIMEOUT)) u_cnt (
        .clk(clk),
        .reset(reset),
        .load(accept),
        .en(waiting),
        .zero(zero),
        .timeout(timeout)
    );

    always_comb begin
        accept  = state == S_IDLE && start && !flush;
        waiting = state inside {S_WAIT_MEM, S_WAIT_MULDIV, S_WAIT_SHIFT};
        ready   = (state == S_WAIT_MEM && zero) ||
                  (state == S_WAIT_MULDIV && !muldiv_busy) ||
                  (state == S_WAIT_SHIFT && shift_done);
        // A source becoming valid on the last allowed wait cycle still completes.
        state_n = flush ? S_IDLE :
                  accept ? route(wb_kind) :
                  ready ? S_WRITE :
                  ((waiting && timeout) || state == S_WRITE) ? S_IDLE : state;
        err_n   = !flush && ((accept && route(wb_kind) == S_IDLE) ||
                             (waiting && !ready && timeout));
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= S_IDLE;
            err        <= 1'b0;
            mem_to_reg <= '0;
            write_reg  <= '0;
        end else begin
            state <= state_n;
            err   <= err_n;
            if (accept) begin
                mem_to_reg <= wb_kind;
                write_reg  <= dest;
            end
        end

    assign busy      = state != S_IDLE;
    assign done      = state == S_WRITE && !flush;
    assign reg_write = done && write_reg != 5'd0;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: scoreboard-driven bench; expected completions are queued as
// requests are issued and matched against DUT output each cycle.
module tb_wb_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] wb_kind = '0;
    logic [4:0] dest = '0;
    logic       muldiv_busy = 1'b0;
    logic       shift_done = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] mem_to_reg;
    logic       reg_write;
    logic [4:0] write_reg;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        int         c;
        bit         rw;
        logic [4:0] wr;
        logic [3:0] m2r;
        bit         dn;
        bit         er;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  t0 = 0;
    int  busy_hi = 0;
    int  checks = 0;
    int  failures = 0;

    wb_sequencer #(.MEM_WAIT(2), .TIMEOUT(64)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .wb_kind(wb_kind),
        .dest(dest),
        .muldiv_busy(muldiv_busy),
        .shift_done(shift_done),
        .flush(flush),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .write_reg(write_reg),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // After return, t0 is the start edge, so cycle k samples with cyc == t0 + k.
    task automatic issue(input logic [3:0] k, input logic [4:0] d);
        @(negedge clk);
        start = 1'b1;
        wb_kind = k;
        dest = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic push(input int k, input bit rw, input logic [4:0] wr,
                        input logic [3:0] m2r, input bit dn, input bit er);
        ev_t e;
        e.c = t0 + k; e.rw = rw; e.wr = wr; e.m2r = m2r; e.dn = dn; e.er = er;
        exp_q.push_back(e);
    endtask

    task automatic run_sb(input string name, input int n);
        ev_t e;
        bit  exp_b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_b = (cyc - t0 >= 1) && (cyc <= busy_hi);
            checks++;
            if (busy !== exp_b) begin
                failures++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, cyc - t0, busy, exp_b);
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (reg_write !== e.rw || done !== e.dn || err !== e.er ||
                    (e.dn && (write_reg !== e.wr || mem_to_reg !== e.m2r))) begin
                    failures++;
                    $display("FAIL %s event cycle %0d: got rw=%b dn=%b er=%b wr=%0d m2r=%0d want rw=%b dn=%b er=%b wr=%0d m2r=%0d",
                             name, cyc - t0, reg_write, done, err, write_reg, mem_to_reg,
                             e.rw, e.dn, e.er, e.wr, e.m2r);
                end
            end else begin
                checks++;
                if (reg_write || done || err) begin
                    failures++;
                    $display("FAIL %s unexpected cycle %0d: got rw=%b dn=%b er=%b want none",
                             name, cyc - t0, reg_write, done, err);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            failures++;
            $display("FAIL %s missing event: got none want at cycle %0d", name, e.c - t0);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_to_reg, write_reg, reg_write, busy, done, err} !== 13'd0) begin
            failures++;
            $display("FAIL reset outputs: got m2r=%0d wr=%0d rw=%b busy=%b dn=%b er=%b want all 0",
                     mem_to_reg, write_reg, reg_write, busy, done, err);
        end
        reset = 1'b0;
        busy_hi = 0;
        run_sb("idle", 2);
    endtask

    task automatic test_alu;
        issue(4'd0, 5'd8);
        push(1, 1, 5'd8, 4'd0, 1, 0);
        busy_hi = t0 + 1;
        run_sb("alu", 3);
    endtask

    task automatic test_back_to_back;
        issue(4'd4, 5'd3);
        push(1, 1, 5'd3, 4'd4, 1, 0);
        busy_hi = t0 + 1;
        run_sb("b2b_first", 1);
        issue(4'd8, 5'd31);
        push(1, 1, 5'd31, 4'd8, 1, 0);
        busy_hi = t0 + 1;
        run_sb("b2b_second", 3);
    endtask

    task automatic test_mdr;
        issue(4'd1, 5'd5);
        checks++;
        if (mem_to_reg !== 4'd1) begin
            failures++;
            $display("FAIL mdr m2r cycle1: got %0d want 1", mem_to_reg);
        end
        push(3, 1, 5'd5, 4'd1, 1, 0);
        busy_hi = t0 + 3;
        run_sb("mdr", 5);
    endtask

    task automatic test_muldiv;
        muldiv_busy = 1'b1;
        issue(4'd2, 5'd9);
        busy_hi = t0 + 11;
        run_sb("muldiv_wait", 10);
        muldiv_busy = 1'b0;
        push(11, 1, 5'd9, 4'd2, 1, 0);
        run_sb("muldiv_write", 3);
        issue(4'd3, 5'd10);
        push(2, 1, 5'd10, 4'd3, 1, 0);
        busy_hi = t0 + 2;
        run_sb("lo_min", 4);
    endtask

    task automatic test_suppress_illegal;
        issue(4'd6, 5'd0);
        push(1, 0, 5'd0, 4'd6, 1, 0);
        busy_hi = t0 + 1;
        run_sb("dest0", 3);
        issue(4'd12, 5'd4);
        push(1, 0, 5'd0, 4'd0, 0, 1);
        busy_hi = t0;
        run_sb("illegal", 3);
    endtask

    task automatic test_timeout_flush;
        shift_done = 1'b0;
        issue(4'd7, 5'd6);
        push(65, 0, 5'd0, 4'd0, 0, 1);
        busy_hi = t0 + 64;
        run_sb("shift_timeout", 67);
        issue(4'd7, 5'd6);
        busy_hi = t0 + 5;
        run_sb("shift_flush_pre", 5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_sb("shift_flush_post", 70);
        shift_done = 1'b1;
        issue(4'd7, 5'd11);
        push(2, 1, 5'd11, 4'd7, 1, 0);
        busy_hi = t0 + 2;
        run_sb("shift_ok", 4);
        shift_done = 1'b0;
    endtask

    task automatic test_flush_write;
        issue(4'd0, 5'd7);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (reg_write !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_write mask: got rw=%b dn=%b want 0 0", reg_write, done);
        end
        flush = 1'b0;
        busy_hi = t0;
        run_sb("flush_write_after", 2);
        flush = 1'b1;
        issue(4'd0, 5'd9);
        flush = 1'b0;
        busy_hi = t0;
        run_sb("flush_over_start", 3);
    endtask

    task automatic test_start_busy;
        issue(4'd1, 5'd5);
        push(3, 1, 5'd5, 4'd1, 1, 0);
        busy_hi = t0 + 3;
        start = 1'b1;
        wb_kind = 4'd0;
        dest = 5'd20;
        run_sb("start_busy_a", 3);
        start = 1'b0;
        run_sb("start_busy_b", 3);
    endtask

    task automatic test_reset_mid;
        issue(4'd1, 5'd13);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_to_reg, write_reg, reg_write, busy, done, err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid outputs: got m2r=%0d wr=%0d rw=%b busy=%b dn=%b er=%b want all 0",
                     mem_to_reg, write_reg, reg_write, busy, done, err);
        end
        @(negedge clk);
        reset = 1'b0;
        busy_hi = 0;
        run_sb("reset_mid_after", 5);
    endtask

    initial begin
        test_reset;
        test_alu;
        test_back_to_back;
        test_mdr;
        test_muldiv;
        test_suppress_illegal;
        test_timeout_flush;
        test_flush_write;
        test_start_busy;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
